// File: rtl/mdu_seq_unit.sv
// Purpose : sequential RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) behind a valid/ready op interface.
// Latency : resp_valid rises 2 edges after accept for MUL*, 33 for DIV/REM, and 1 for divide-by-zero or signed overflow.
// Backpr. : one op in flight; req_ready only in IDLE; Result/resp_tag are held in DONE until resp_ready.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             aborts any in-flight op and drops a pending response
//   req_valid/ready   op handshake; operand1, operand2, mul_div_op, req_tag are sampled at accept
//   resp_valid/ready  result handshake; Result and resp_tag are valid while resp_valid=1
//   busy              high whenever the unit is not IDLE (pipeline stall)
module mdu_seq_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  operand1,
  input  logic [XLEN-1:0]  operand2,
  input  logic [3:0]       mul_div_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  Result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // opa holds op1 (MUL) or the shifting dividend/quotient (DIV);
  // opb holds op2 (MUL) or the divisor magnitude (DIV).
  logic [XLEN-1:0]  opa_q, opa_d;
  logic [XLEN-1:0]  opb_q, opb_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [1:0]       fn_q, fn_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             resp_valid_q, resp_valid_d;
  logic             req_ready_q, req_ready_d;

  // Request decode (only meaningful at the accept edge)
  logic            accept;
  logic            div_signed;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;

  // Datapath terms
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] prod;
  logic              a_sgn;
  logic              b_sgn;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   step_rem;
  logic [XLEN-1:0]   step_quo;

  always_comb begin
    accept     = req_valid & req_ready_q & ~mul_div_op[3] & ~flush;
    // func3 4 (DIV) and 6 (REM) are signed; 5 and 7 are unsigned
    div_signed = ~mul_div_op[0];
    div_zero   = (operand2 == '0);
    div_ovf    = div_signed & (operand1 == INT_MIN) & (operand2 == '1);
    abs1       = (div_signed & operand1[XLEN-1]) ? -operand1 : operand1;
    abs2       = (div_signed & operand2[XLEN-1]) ? -operand2 : operand2;

    // MULH: signed x signed; MULHSU: signed x unsigned; MULHU and MUL: unsigned.
    // The low 2*XLEN bits of the product of the extended operands are exact.
    a_sgn = (fn_q == 2'd1) | (fn_q == 2'd2);
    b_sgn = (fn_q == 2'd1);
    mul_a = {{XLEN{a_sgn & opa_q[XLEN-1]}}, opa_q};
    mul_b = {{XLEN{b_sgn & opb_q[XLEN-1]}}, opb_q};
    prod  = mul_a * mul_b;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The true difference is < divisor, so
    // its low XLEN bits are exact.
    shifted  = {rem_q, opa_q[XLEN-1]};
    ge       = (shifted >= {1'b0, opb_q});
    step_rem = ge ? (shifted[XLEN-1:0] - opb_q) : shifted[XLEN-1:0];
    step_quo = {opa_q[XLEN-2:0], ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    fn_d     = fn_q;
    tag_d    = tag_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          fn_d  = mul_div_op[1:0];
          tag_d = req_tag;
          cnt_d = '0;
          rem_d = '0;
          if (!mul_div_op[2]) begin
            opa_d   = operand1;
            opb_d   = operand2;
            state_d = S_MUL;
          end else if (div_zero) begin
            result_d = mul_div_op[1] ? operand1 : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = mul_div_op[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            opa_d   = abs1;
            opb_d   = abs2;
            negq_d  = div_signed & (operand1[XLEN-1] ^ operand2[XLEN-1]);
            negr_d  = div_signed & operand1[XLEN-1];
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = (fn_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end
      S_DIV: begin
        opa_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Sign fix folded into the last iteration edge
          if (fn_q[1]) begin
            result_d = negr_q ? -step_rem : step_rem;
          end else begin
            result_d = negq_q ? -step_quo : step_quo;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_valid_q & resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything; with resp_ready also high in DONE the
    // response was already taken, so leaving to IDLE is correct either way.
    if (flush) begin
      state_d = S_IDLE;
    end

    // resp_valid trails entry into DONE by one edge and drops on leaving it
    resp_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
    req_ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rem_q        <= '0;
      fn_q         <= '0;
      tag_q        <= '0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rem_q        <= rem_d;
      fn_q         <= fn_d;
      tag_q        <= tag_d;
      negq_q       <= negq_d;
      negr_q       <= negr_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign Result     = result_q;
  assign resp_tag   = tag_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Purpose : directed bench for mdu_seq_unit with hand-computed results and latencies.
// Latency : latency is counted in rising edges from the accept edge to resp_valid first seen high.
// Backpr. : resp_ready is normally held high; one sequence holds it low to check result hold.
module tb_mdu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [3:0]  mul_div_op;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] Result;
  logic [4:0]  resp_tag;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_seq_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .operand1   (operand1),
    .operand2   (operand2),
    .mul_div_op (mul_div_op),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .Result     (Result),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every step lands 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency, check result/tag, let the handshake complete.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [4:0] tag,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    step();
    chk({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    operand1   = a;
    operand2   = b;
    mul_div_op = op;
    req_tag    = tag;
    req_valid  = 1'b1;
    step();                       // accept edge
    req_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!resp_valid && lat < 60);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, Result, exp_res);
    chk({name, " tag"}, {27'd0, resp_tag}, {27'd0, tag});
    step();                       // handshake edge (resp_ready=1)
    chk({name, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    operand1   = '0;
    operand2   = '0;
    mul_div_op = '0;
    req_tag    = '0;
    resp_ready = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst result", Result, 32'd0);
    chk("rst tag", {27'd0, resp_tag}, 32'd0);
    reset = 1'b0;
    step();
    chk("post rst req_ready", {31'd0, req_ready}, 32'd1);

    // Multiplies
    run_op("MUL 7*-3",      32'd7,        32'hFFFFFFFD, 4'd0, 5'd1, 32'hFFFFFFEB, 2);
    run_op("MULHU max",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 5'd2, 32'hFFFFFFFE, 2);
    run_op("MULHSU -1",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 5'd3, 32'hFFFFFFFF, 2);
    run_op("MULH min*min",  32'h80000000, 32'h80000000, 4'd1, 5'd4, 32'h40000000, 2);
    run_op("MULH -1*-1",    32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 5'd5, 32'h00000000, 2);

    // Iterative divides
    run_op("DIV -7/2",      32'hFFFFFFF9, 32'd2,        4'd4, 5'd6, 32'hFFFFFFFD, 33);
    run_op("REM -7/2",      32'hFFFFFFF9, 32'd2,        4'd6, 5'd7, 32'hFFFFFFFF, 33);
    run_op("DIVU 100/7",    32'd100,      32'd7,        4'd5, 5'd8, 32'd14,       33);
    run_op("REMU 100/7",    32'd100,      32'd7,        4'd7, 5'd9, 32'd2,        33);
    run_op("REMU min/max",  32'h80000000, 32'hFFFFFFFF, 4'd7, 5'd10, 32'h80000000, 33);
    run_op("DIV 7/-2",      32'd7,        32'hFFFFFFFE, 4'd4, 5'd11, 32'hFFFFFFFD, 33);

    // Special cases
    run_op("DIV 5/0",       32'd5,        32'd0,        4'd4, 5'd12, 32'hFFFFFFFF, 1);
    run_op("REM 5/0",       32'd5,        32'd0,        4'd6, 5'd13, 32'd5,        1);
    run_op("DIVU 5/0",      32'd5,        32'd0,        4'd5, 5'd14, 32'hFFFFFFFF, 1);
    run_op("DIV ovf",       32'h80000000, 32'hFFFFFFFF, 4'd4, 5'd15, 32'h80000000, 1);
    run_op("REM ovf",       32'h80000000, 32'hFFFFFFFF, 4'd6, 5'd16, 32'd0,        1);

    // Non-M op is ignored
    operand1   = 32'd3;
    operand2   = 32'd4;
    mul_div_op = 4'b1000;
    req_valid  = 1'b1;
    repeat (3) begin
      step();
      chk("nonM busy", {31'd0, busy}, 32'd0);
      chk("nonM resp_valid", {31'd0, resp_valid}, 32'd0);
    end
    req_valid = 1'b0;

    // Flush in IDLE blocks acceptance
    mul_div_op = 4'd0;
    req_valid  = 1'b1;
    flush      = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    seen = 0;
    repeat (4) begin
      step();
      if (busy || resp_valid) seen++;
    end
    chk("flush idle no accept", seen, 0);

    // Backpressure
    resp_ready = 1'b0;
    step();
    operand1   = 32'd3;
    operand2   = 32'd5;
    mul_div_op = 4'd0;
    req_tag    = 5'd21;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    seen = 0;
    while (!resp_valid && seen < 10) begin
      step();
      seen++;
    end
    chk("bp latency", seen, 2);
    repeat (10) begin
      step();
      chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp result", Result, 32'd15);
      chk("bp tag", {27'd0, resp_tag}, 32'd21);
      chk("bp busy", {31'd0, busy}, 32'd1);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("bp release resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp release busy", {31'd0, busy}, 32'd0);
    chk("bp release req_ready", {31'd0, req_ready}, 32'd1);

    // Flush at iteration 10 of a DIV
    step();
    operand1   = 32'd1000;
    operand2   = 32'd3;
    mul_div_op = 4'd4;
    req_tag    = 5'd22;
    req_valid  = 1'b1;
    step();                       // accept edge
    req_valid = 1'b0;
    repeat (10) step();           // iterations 0..9
    flush = 1'b1;
    step();                       // iteration 10 edge
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush resp_valid", {31'd0, resp_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (resp_valid) seen++;
    end
    chk("flush no response", seen, 0);
    run_op("MUL after flush", 32'd3, 32'd4, 4'd0, 5'd17, 32'd12, 2);

    // Reset at iteration 10 of a DIV
    step();
    operand1   = 32'd1000;
    operand2   = 32'd3;
    mul_div_op = 4'd4;
    req_tag    = 5'd23;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst result", Result, 32'd0);
    step();
    chk("midrst req_ready after", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (resp_valid) seen++;
    end
    chk("midrst no response", seen, 0);
    run_op("MUL after reset", 32'd3, 32'd4, 4'd0, 5'd18, 32'd12, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
